// File: rtl/speaker_src_arbiter.sv
// Round-robin, frame-sliced arbiter sharing the I2S speaker datapath between two sources.
// Optional build macro SPK_ARB_VOLUME_EN adds a per-sample arithmetic attenuation by vol.
module speaker_src_arbiter #(
   parameter int unsigned SLOT_FRAMES = 4096,
   parameter int unsigned GAP_FRAMES  = 2,
   parameter int unsigned CNT_W       = 12
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        audio_ws,
   input  logic [1:0]  req,
   input  logic [15:0] src0_left,
   input  logic [15:0] src0_right,
   input  logic [15:0] src1_left,
   input  logic [15:0] src1_right,
   input  logic [2:0]  vol,
   output logic [1:0]  gnt,
   output logic        frame_tick,
   output logic        busy,
   output logic [15:0] audio_in_left,
   output logic [15:0] audio_in_right
);

   localparam logic [CNT_W-1:0] SlotLast = CNT_W'(SLOT_FRAMES - 1);
   localparam logic [CNT_W-1:0] GapLast  = CNT_W'(GAP_FRAMES - 1);

   typedef enum logic [1:0] {StIdle, StGrant, StGap} state_e;

   state_e           state_q, state_d;
   logic             ws_q;
   logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
   logic [CNT_W-1:0] gap_cnt_q, gap_cnt_d;
   logic             last_q, last_d;
   logic [1:0]       gnt_q, gnt_d;
   logic [15:0]      left_q, left_d;
   logic [15:0]      right_q, right_d;

   logic             win;
   logic             pick;
   logic [15:0]      raw_left, raw_right;
   logic [15:0]      lat_left, lat_right;

   assign frame_tick = audio_ws & ~ws_q;

   // Tie goes to the source that did not win last; last_q is also the owner while granted.
   always_comb begin
      win = 1'b0;
      if (req == 2'b11) begin
         win = ~last_q;
      end else if (req[1]) begin
         win = 1'b1;
      end
   end

   assign pick      = (state_q == StIdle) ? win : last_q;
   assign raw_left  = pick ? src1_left  : src0_left;
   assign raw_right = pick ? src1_right : src0_right;

`ifdef SPK_ARB_VOLUME_EN
   assign lat_left  = $signed(raw_left)  >>> vol;
   assign lat_right = $signed(raw_right) >>> vol;
`else
   logic unused_vol;
   assign unused_vol = ^vol;
   assign lat_left   = raw_left;
   assign lat_right  = raw_right;
`endif

   always_comb begin
      state_d     = state_q;
      frame_cnt_d = frame_cnt_q;
      gap_cnt_d   = gap_cnt_q;
      last_d      = last_q;
      gnt_d       = gnt_q;
      left_d      = left_q;
      right_d     = right_q;

      if (frame_tick) begin
         unique case (state_q)
            StIdle: begin
               left_d  = '0;
               right_d = '0;
               gnt_d   = 2'b00;
               if (|req) begin
                  state_d     = StGrant;
                  last_d      = win;
                  gnt_d       = win ? 2'b10 : 2'b01;
                  frame_cnt_d = '0;
                  left_d      = lat_left;
                  right_d     = lat_right;
               end
            end
            StGrant: begin
               if (!req[last_q] || ((frame_cnt_q == SlotLast) && req[~last_q])) begin
                  state_d   = StGap;
                  gnt_d     = 2'b00;
                  left_d    = '0;
                  right_d   = '0;
                  gap_cnt_d = '0;
               end else begin
                  frame_cnt_d = (frame_cnt_q == SlotLast) ? '0 : frame_cnt_q + 1'b1;
                  left_d      = lat_left;
                  right_d     = lat_right;
               end
            end
            StGap: begin
               left_d  = '0;
               right_d = '0;
               gnt_d   = 2'b00;
               if (gap_cnt_q == GapLast) begin
                  state_d = StIdle;
               end else begin
                  gap_cnt_d = gap_cnt_q + 1'b1;
               end
            end
            default: begin
               state_d = StIdle;
               gnt_d   = 2'b00;
               left_d  = '0;
               right_d = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         ws_q        <= 1'b1;
         frame_cnt_q <= '0;
         gap_cnt_q   <= '0;
         last_q      <= 1'b1;
         gnt_q       <= 2'b00;
         left_q      <= '0;
         right_q     <= '0;
      end else begin
         state_q     <= state_d;
         ws_q        <= audio_ws;
         frame_cnt_q <= frame_cnt_d;
         gap_cnt_q   <= gap_cnt_d;
         last_q      <= last_d;
         gnt_q       <= gnt_d;
         left_q      <= left_d;
         right_q     <= right_d;
      end
   end

   assign gnt            = gnt_q;
   assign busy           = (state_q != StIdle);
   assign audio_in_left  = left_q;
   assign audio_in_right = right_q;

   gnt_onehot_a: assert property (@(posedge clk) $onehot0(gnt));

endmodule

// File: tb/tb_speaker_src_arbiter.sv
// Scoreboard bench for speaker_src_arbiter: a frame-level model predicts each tick's outputs.
module tb_speaker_src_arbiter;

   localparam int SLOT = 4;
   localparam int GAP  = 2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        audio_ws = 1'b1;
   bit   [7:0]  ws_cnt = 8'd0;
   logic [1:0]  req = 2'b00;
   logic [15:0] s0l = '0, s0r = '0, s1l = '0, s1r = '0;
   logic [2:0]  vol = '0;
   logic [1:0]  gnt;
   logic        frame_tick, busy;
   logic [15:0] out_l, out_r;

   int checks = 0;
   int errors = 0;

   speaker_src_arbiter #(
      .SLOT_FRAMES(SLOT),
      .GAP_FRAMES (GAP),
      .CNT_W      (12)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .audio_ws      (audio_ws),
      .req           (req),
      .src0_left     (s0l),
      .src0_right    (s0r),
      .src1_left     (s1l),
      .src1_right    (s1r),
      .vol           (vol),
      .gnt           (gnt),
      .frame_tick    (frame_tick),
      .busy          (busy),
      .audio_in_left (out_l),
      .audio_in_right(out_r)
   );

   always #5 clk = ~clk;

   // 256-clk frame: 128 cycles high then 128 low, starting high.
   always @(posedge clk) begin
      #2;
      ws_cnt   = ws_cnt + 8'd1;
      audio_ws = ~ws_cnt[7];
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [15:0] atten(input logic [15:0] s, input logic [2:0] v);
`ifdef SPK_ARB_VOLUME_EN
      return $signed(s) >>> v;
`else
      return (v == 3'd0) ? s : s;
`endif
   endfunction

   typedef struct packed {
      logic [1:0]  gnt;
      logic        busy;
      logic [15:0] l;
      logic [15:0] r;
   } exp_t;

   exp_t exp_q[$];

   // Frame-level model: owner (-1 none), frames played in current slot, silent frames left.
   int          m_owner = -1;
   int          m_held = 0;
   int          m_gap = 0;
   int          m_last = 1;
   bit          m_ws_prev = 1'b1;
   int          tick_count = 0;
   logic [15:0] m_l = '0, m_r = '0;

   always @(posedge clk) begin : model
      exp_t e;
      if (!rst_n) begin
         m_owner = -1; m_held = 0; m_gap = 0; m_last = 1; m_ws_prev = 1'b1;
         m_l = '0; m_r = '0;
      end else if (audio_ws && !m_ws_prev) begin
         m_ws_prev = audio_ws;
         if (m_gap > 0) begin
            m_gap--;
         end else if (m_owner < 0) begin
            if (req != 2'b00) begin
               m_owner = (req == 2'b11) ? 1 - m_last : (req[1] ? 1 : 0);
               m_last  = m_owner;
               m_held  = 1;
            end
         end else if (!req[m_owner] || (m_held == SLOT && req[1-m_owner])) begin
            m_owner = -1;
            m_gap   = GAP;
         end else begin
            m_held = (m_held == SLOT) ? 1 : m_held + 1;
         end
         if (m_owner >= 0 && m_gap == 0) begin
            m_l = atten(m_owner == 1 ? s1l : s0l, vol);
            m_r = atten(m_owner == 1 ? s1r : s0r, vol);
         end else begin
            m_l = '0; m_r = '0;
         end
         e.gnt  = (m_owner < 0) ? 2'b00 : (m_owner == 1 ? 2'b10 : 2'b01);
         e.busy = (m_owner >= 0) || (m_gap > 0);
         e.l    = m_l;
         e.r    = m_r;
         exp_q.push_back(e);
         tick_count++;
      end else begin
         m_ws_prev = audio_ws;
      end
   end

   // Monitor: a DUT frame_tick means fresh outputs one edge later.
   bit pend = 1'b0;
   always @(negedge clk) begin : monitor
      exp_t e;
      if (pend) begin
         pend = 1'b0;
         if (exp_q.size() == 0) begin
            chk("unexpected_tick", 32'd1, 32'd0);
         end else begin
            e = exp_q.pop_front();
            chk("tick_gnt", gnt, e.gnt);
            chk("tick_busy", busy, e.busy);
            chk("tick_left", out_l, e.l);
            chk("tick_right", out_r, e.r);
         end
      end
      if (rst_n && frame_tick) pend = 1'b1;
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic wait_ticks(input int n);
      int target;
      int guard;
      target = tick_count + n;
      guard  = 0;
      while (tick_count < target && guard < n * 300 + 300) begin
         step();
         guard++;
      end
      if (tick_count < target) chk("tick_timeout", tick_count, target);
   endtask

   initial begin
      repeat (4) step();
      rst_n = 1'b1;
      @(negedge clk);
      chk("reset_gnt", gnt, 2'b00);
      chk("reset_busy", busy, 1'b0);
      chk("reset_left", out_l, 16'h0000);
      chk("reset_right", out_r, 16'h0000);
      for (int i = 0; i < 260 && audio_ws; i++) begin
         chk("no_tick_while_ws_high", frame_tick, 1'b0);
         @(negedge clk);
      end

      step();
      req = 2'b01; s0l = 16'h1234; s0r = 16'hABCD;
      wait_ticks(1);
      @(negedge clk);
      chk("first_grant_gnt", gnt, 2'b01);
      chk("first_grant_left", out_l, 16'h1234);
      chk("first_grant_right", out_r, 16'hABCD);
      chk("first_grant_busy", busy, 1'b1);
      wait_ticks(2);
      req = 2'b00;
      wait_ticks(4);

      s1l = 16'h5555; s1r = 16'h6666;
      req = 2'b11;
      wait_ticks(14);
      req = 2'b00;
      wait_ticks(4);

      req = 2'b01;
      wait_ticks(10);
      @(negedge clk);
      chk("solo_keeps_gnt", gnt, 2'b01);
      step();
      req = 2'b00;
      wait_ticks(4);

      req = 2'b11;
      wait_ticks(2);
      repeat (50) step();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      @(negedge clk);
      chk("midreset_gnt", gnt, 2'b00);
      chk("midreset_busy", busy, 1'b0);
      chk("midreset_left", out_l, 16'h0000);
      wait_ticks(2);
      @(negedge clk);
      chk("post_reset_src0_first", gnt, 2'b01);
      step();
      req = 2'b00;
      wait_ticks(6);

      s1l = 16'h8000; vol = 3'd3; req = 2'b10;
      wait_ticks(2);
      @(negedge clk);
`ifdef SPK_ARB_VOLUME_EN
      chk("vol_left", out_l, 16'hF000);
`else
      chk("vol_left", out_l, 16'h8000);
`endif
      step();
      req = 2'b00;
      wait_ticks(4);

      for (int k = 0; k < 120; k++) begin
         int hold;
         hold = $urandom_range(700, 40);
         req  = 2'($urandom_range(3, 0));
         vol  = 3'($urandom);
         repeat (hold) begin
            s0l = 16'($urandom); s0r = 16'($urandom);
            s1l = 16'($urandom); s1r = 16'($urandom);
            step();
         end
      end

      step();
      @(negedge clk);
      @(negedge clk);
      chk("queue_drained", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
